// File: rtl/seq_state_shell.sv
// Sequential wrapper stepping a cut combinational core once per in/out handshake; optional MISR via SEQ_STATE_SHELL_MISR_EN.
// Latency: response valid one cycle after the accept edge (single EVAL cycle).
// Backpressure: holds response until out_ready; in_ready follows out_ready while holding, 1 step per 2 cycles.
module seq_state_shell #(
  parameter logic [5:0] RESET_STATE = 6'h00,
  parameter int         STEP_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_pi,
  input  logic              load_valid,
  input  logic [5:0]        load_state,
  output logic [6:0]        core_pi,
  output logic [5:0]        core_state,
  input  logic [6:0]        core_po,
  input  logic [5:0]        core_ns,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [6:0]        out_po,
  output logic [5:0]        out_state,
  output logic [STEP_W-1:0] step_cnt
`ifdef SEQ_STATE_SHELL_MISR_EN
  ,
  output logic [15:0]       sig
`endif
);

  typedef enum logic [1:0] {IDLE, EVAL, HOLD} fsm_t;

  fsm_t fsm_q, fsm_d;
  logic accept;
  logic load_en;
  logic eval_done;

  always_comb begin
    fsm_d     = fsm_q;
    in_ready  = 1'b0;
    load_en   = 1'b0;
    eval_done = 1'b0;
    case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        load_en  = load_valid;
        if (in_valid) fsm_d = EVAL;
      end
      EVAL: begin
        eval_done = 1'b1;
        fsm_d     = HOLD;
      end
      HOLD: begin
        in_ready = out_ready;
        if (out_ready) begin
          load_en = load_valid;
          fsm_d   = in_valid ? EVAL : IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign accept    = in_valid & in_ready;
  assign out_valid = (fsm_q == HOLD);

  // load_en and eval_done never coincide, so the load lands before the EVAL it precedes
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q      <= IDLE;
      core_state <= RESET_STATE;
      core_pi    <= '0;
      out_po     <= '0;
      out_state  <= RESET_STATE;
      step_cnt   <= '0;
    end else begin
      fsm_q <= fsm_d;
      if (accept) core_pi <= in_pi;
      if (eval_done) begin
        core_state <= core_ns;
        out_po     <= core_po;
        out_state  <= core_ns;
        step_cnt   <= step_cnt + {{(STEP_W-1){1'b0}}, 1'b1};
      end else if (load_en) begin
        core_state <= load_state;
      end
    end
  end

`ifdef SEQ_STATE_SHELL_MISR_EN
  // Galois shift for x^16+x^12+x^5+1, then fold in this step's PO and next state
  always_ff @(posedge clk) begin
    if (rst) begin
      sig <= 16'hFFFF;
    end else if (eval_done) begin
      sig <= {sig[14:0], 1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000) ^ {3'b000, core_po, core_ns};
    end
  end
`endif

endmodule

// File: doc/seq_state_shell.md
Name: seq_state_shell

Overview:
- Sequential closure for a cut combinational controller core (7 primary inputs, 6 state bits, 7 primary outputs, 6 next-state outputs).
- Owns the 6 state flops the core was cut from. Drives the core's PI and state inputs, and captures its PO and next-state outputs.
- Exchanges one evaluation step per valid/ready transaction, so the core can be stepped from a stream source and observed by a stream sink.

Parameters:
- RESET_STATE, 6'h00: state register value applied on reset.
- STEP_W, 16: width of the step counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  stimulus vector valid.
- in_ready  out  1  shell can accept a stimulus vector.
- in_pi  in  7  stimulus; bit0..bit6 = core PI v0..v6.
- load_valid  in  1  force-load the state register.
- load_state  in  6  value for force-load.
- core_pi  out  7  registered PI driven to the core.
- core_state  out  6  current state; bit0..bit5 = core v7..v12.
- core_po  in  7  core primary outputs, in core port order g528,g534,g535,g537,g560,g722,g754.
- core_ns  in  6  core next-state outputs D_6,D_7,D_9,D_10,D_11,D_12; bit i feeds state bit i.
- out_valid  out  1  response valid.
- out_ready  in  1  sink accepts response.
- out_po  out  7  captured PO for the step.
- out_state  out  6  state after the step.
- step_cnt  out  STEP_W  completed steps.

Behaviour:
- Reset values: state = RESET_STATE; core_pi = 0; out_valid = 0; out_po = 0; out_state = RESET_STATE; step_cnt = 0; FSM = IDLE.
- FSM states: IDLE, EVAL, HOLD.
  - IDLE: in_ready = 1. When in_valid is high, core_pi <= in_pi and go to EVAL.
  - EVAL: exactly one cycle, in_ready = 0. The core sees the stable core_pi and core_state. At the end of the cycle: state <= core_ns; out_po <= core_po; out_state <= core_ns; out_valid <= 1; step_cnt += 1 (wraps modulo 2^STEP_W); go to HOLD.
  - HOLD: out_valid = 1 and out_po/out_state are held stable.
    - in_ready = out_ready, i.e. back-to-back throughput of 1 step per 2 cycles.
    - out_ready = 1 and in_valid = 1: accept the new in_pi and go to EVAL; out_valid drops.
    - out_ready = 1 and in_valid = 0: go to IDLE; out_valid drops.
    - out_ready = 0: stay in HOLD.
- Latency: accept edge to out_valid = 1 cycle. The core is purely combinational; no second-edge sampling.
- Force-load:
  - Honoured only in IDLE, or in HOLD when out_ready = 1: state <= load_state. out_state and step_cnt are unchanged.
  - If in_valid is also accepted in the same cycle, the load takes effect first and the next EVAL uses load_state.
  - Ignored in EVAL, and ignored in HOLD when out_ready = 0.
- core_state always mirrors the state register.
- in_pi is ignored whenever in_ready = 0.
- rst during EVAL or HOLD:
  - The pending response is discarded; out_valid = 0 on the next cycle; state = RESET_STATE.
  - A response is never emitted after reset assertion.
- step_cnt at all-ones followed by a step gives 0, with no flag.

Optional Feature:
- Macro: SEQ_STATE_SHELL_MISR_EN.
- Enabled: adds output port sig (16 bits), a MISR with polynomial x^16+x^12+x^5+1.
  - Reset value 16'hFFFF.
  - On each EVAL completion: sig <= shift(sig) XOR {3'b0, core_po, core_ns}.
  - Unchanged by force-load.
- Disabled: no port and no logic. All other behaviour is identical.

Test Plan:
(Bench core model: core_ns = ~in_pi[5:0]; core_po = {in_pi[6], core_state}.)
1. Reset with RESET_STATE = 6'h00, then in_pi = 7'h41 for one cycle with out_ready = 1 -> one cycle later: out_valid = 1, out_po = 7'h40, out_state = 6'h3E, step_cnt = 1.
2. out_ready = 0 for 5 cycles after test 1 -> out_valid stays 1, out_po/out_state stay constant, in_ready = 0; then out_ready = 1 with in_pi = 7'h00 -> out_state = 6'h3F, out_po = 7'h3E, step_cnt = 2.
3. Continuous in_valid = 1, out_ready = 1 for 20 cycles -> exactly 10 responses and step_cnt = 10.
4. load_valid = 1 with load_state = 6'h2A in IDLE, plus in_pi = 7'h00 in the same cycle -> out_po = 7'h2A and out_state = 6'h3F; a load attempted in EVAL leaves state unchanged.
5. rst asserted in the EVAL cycle -> out_valid = 0 the next cycle, core_state = RESET_STATE, step_cnt = 0, and no response appears afterwards.
6. STEP_W = 4, 17 steps -> step_cnt = 1. With SEQ_STATE_SHELL_MISR_EN, sig after the single step of test 1 matches the bench MISR model; without the macro, the build has no sig port.
